// File: rtl/kbd_cmd_decoder.sv
// PS/2 scancode -> synchronised, debounced single-cycle command pulses plus CLOCK/GAME/PAUSE mode FSM.
// Define KBD_TYPEMATIC_EN to add auto-repeat of held arrow keys in GAME mode.
module kbd_cmd_decoder #(
  parameter int STABLE_CYC    = 16,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [8:0] scancode,
  input  logic       Released,
  output logic       enter_p,
  output logic       space_p,
  output logic       esc_p,
  output logic       up_p,
  output logic       down_p,
  output logic       left_p,
  output logic       right_p,
  output logic       key_held,
  output logic [1:0] mode,
  output logic       gamestart
);

  localparam logic [8:0] CODE_ENTER = 9'h05A;
  localparam logic [8:0] CODE_SPACE = 9'h029;
  localparam logic [8:0] CODE_ESC   = 9'h076;
  localparam logic [8:0] CODE_UP    = 9'h175;
  localparam logic [8:0] CODE_DOWN  = 9'h172;
  localparam logic [8:0] CODE_LEFT  = 9'h16B;
  localparam logic [8:0] CODE_RIGHT = 9'h174;
  localparam logic [9:0] IDLE_VAL   = {9'h000, 1'b1};
  localparam int         CW         = $clog2(STABLE_CYC + 1);

  if (STABLE_CYC < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("kbd_cmd_decoder: invalid timing parameters");
  end

  typedef enum logic [1:0] {
    ST_CLOCK = 2'b00,
    ST_GAME  = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } mode_e;

  // pulse bit order: enter, space, esc, up, down, left, right
  logic [9:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d, stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    pulse_q, pulse_d;
  logic          key_held_q, key_held_d;
  mode_e         mode_q, mode_d;
  logic          load, evt, press;
  logic [8:0]    new_code;

  function automatic logic is_known(input logic [8:0] c);
    return c inside {CODE_ENTER, CODE_SPACE, CODE_ESC, CODE_UP, CODE_DOWN, CODE_LEFT, CODE_RIGHT};
  endfunction

`ifdef KBD_TYPEMATIC_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [3:0]    rpt_key_q, rpt_key_d;
  logic          rpt_on_q, rpt_on_d, rpt_first_q, rpt_first_d;
`endif

  always_comb begin
    sync1_d = {scancode, Released};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    if (sync2_q != prev_q)                 cnt_d = '0;
    else if (cnt_q != CW'(STABLE_CYC))     cnt_d = cnt_q + 1'b1;
    else                                   cnt_d = cnt_q;
    // load exactly once, on the cycle the counter first reaches its limit
    load     = (cnt_d == CW'(STABLE_CYC)) && (cnt_q != CW'(STABLE_CYC));
    stable_d = load ? sync2_q : stable_q;
    evt      = load && (sync2_q != stable_q);
    press    = evt && !sync2_q[0];
    new_code = sync2_q[9:1];

    pulse_d = '0;
    if (press) begin
      case (new_code)
        CODE_ENTER: pulse_d[0] = 1'b1;
        CODE_SPACE: pulse_d[1] = 1'b1;
        CODE_ESC:   pulse_d[2] = 1'b1;
        CODE_UP:    pulse_d[3] = (mode_q == ST_GAME);
        CODE_DOWN:  pulse_d[4] = (mode_q == ST_GAME);
        CODE_LEFT:  pulse_d[5] = (mode_q == ST_GAME);
        CODE_RIGHT: pulse_d[6] = (mode_q == ST_GAME);
        default:    pulse_d = '0;
      endcase
    end

    mode_d = mode_q;
    case (mode_q)
      ST_CLOCK: if (pulse_d[0]) mode_d = ST_GAME;
      ST_GAME: begin
        if (pulse_d[1])      mode_d = ST_PAUSE;
        else if (pulse_d[2]) mode_d = ST_CLOCK;
      end
      ST_PAUSE: begin
        if (pulse_d[1] || pulse_d[0]) mode_d = ST_GAME;
        else if (pulse_d[2])          mode_d = ST_CLOCK;
      end
      default: mode_d = ST_CLOCK;
    endcase

    key_held_d = !stable_d[0] && is_known(stable_d[9:1]);

`ifdef KBD_TYPEMATIC_EN
    rpt_on_d    = rpt_on_q;
    rpt_key_d   = rpt_key_q;
    rpt_first_d = rpt_first_q;
    rpt_cnt_d   = rpt_cnt_q;
    if (evt) begin
      // any new event restarts or cancels repeat; only a GAME arrow press arms it
      rpt_on_d    = |pulse_d[6:3];
      rpt_key_d   = pulse_d[6:3];
      rpt_first_d = 1'b0;
      rpt_cnt_d   = '0;
    end else if (rpt_on_q) begin
      rpt_cnt_d = rpt_cnt_q + 1'b1;
      if ((!rpt_first_q && rpt_cnt_d == RW'(REPEAT_DELAY)) ||
          (rpt_first_q && rpt_cnt_d == RW'(REPEAT_PERIOD))) begin
        pulse_d[6:3] = rpt_key_q;
        rpt_cnt_d    = '0;
        rpt_first_d  = 1'b1;
      end
    end
    if (mode_d != ST_GAME) begin
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
    end
`endif
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync1_q    <= IDLE_VAL;
      sync2_q    <= IDLE_VAL;
      prev_q     <= IDLE_VAL;
      stable_q   <= IDLE_VAL;
      cnt_q      <= '0;
      pulse_q    <= '0;
      key_held_q <= 1'b0;
      mode_q     <= ST_CLOCK;
`ifdef KBD_TYPEMATIC_EN
      rpt_on_q    <= 1'b0;
      rpt_key_q   <= '0;
      rpt_first_q <= 1'b0;
      rpt_cnt_q   <= '0;
`endif
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      key_held_q <= key_held_d;
      mode_q     <= mode_d;
`ifdef KBD_TYPEMATIC_EN
      rpt_on_q    <= rpt_on_d;
      rpt_key_q   <= rpt_key_d;
      rpt_first_q <= rpt_first_d;
      rpt_cnt_q   <= rpt_cnt_d;
`endif
    end
  end

  assign enter_p   = pulse_q[0];
  assign space_p   = pulse_q[1];
  assign esc_p     = pulse_q[2];
  assign up_p      = pulse_q[3];
  assign down_p    = pulse_q[4];
  assign left_p    = pulse_q[5];
  assign right_p   = pulse_q[6];
  assign key_held  = key_held_q;
  assign mode      = mode_q;
  assign gamestart = (mode_q != ST_CLOCK);

endmodule
